// File: rtl/spislave_pkg.sv
// Shared types and helpers for the SPI slave frame interface.
package spislave_pkg;

   localparam int unsigned HDR_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_CHECK  = 2'd2
   } spi_state_t;

   // Header travels LSB byte first, so the expected on-wire header is the byte-reversed MSGID.
   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

endpackage

// File: rtl/spislave_sync.sv
// Three-stage synchroniser for an asynchronous SPI pin, with edge strobes aligned to the level output.
module spislave_sync #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [2:0] sync_q;

   // Shift chain; edges are registered from stages 0/1 so they line up with stages 1/2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {3{RESET_VAL}};
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], din};
         rise   <= sync_q[0] & ~sync_q[1];
         fall   <= ~sync_q[0] & sync_q[1];
      end
   end

   assign dout = sync_q[1];

endmodule

// File: rtl/interface_spislave_ext.sv
// SPI slave frame interface: oversampled SPI pins, fixed-length frame exchange,
// header/length validation, error counting and packet timeout.
module interface_spislave_ext
   import spislave_pkg::*;
#(
   parameter int unsigned BUFFER_SIZE = 96,
   parameter logic [31:0] MSGID       = 32'h74697277,
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter logic [31:0] TIMEOUT     = 32'd4_800_000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   SPI_SCK,
   input  logic                   SPI_SSEL,
   input  logic                   SPI_MOSI,
   output logic                   SPI_MISO,
   input  logic [BUFFER_SIZE-1:0] tx_data,
   output logic [BUFFER_SIZE-1:0] rx_data,
   output logic                   rx_valid,
   output logic                   frame_err,
   output logic [7:0]             err_count,
   output logic                   pkg_timeout
);

   localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BUFFER_SIZE + 1);
   localparam logic [HDR_WIDTH-1:0] HDR_EXP = bswap32(MSGID);

   logic sck_lvl, sck_rise, sck_fall;
   logic ssel_lvl, ssel_rise, ssel_fall;
   logic mosi_s, mosi_rise, mosi_fall;
   logic unused_sig;

   spi_state_t             state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [BUFFER_SIZE-1:0] rx_sreg;
   logic [BUFFER_SIZE-1:0] tx_sreg;
   logic                   miso_q;
   logic                   lead_edge, trail_edge, sample_edge, shift_edge;
   logic                   frame_ok, reload;
   logic [31:0]            tmo_cnt, tmo_next;

   // SCK idles at CPOL and SSEL comes out of reset low so a chip select already
   // asserted during reset never looks like a fresh frame start.
   spislave_sync #(.RESET_VAL(CPOL)) u_sync_sck (
      .clk(clk), .reset(reset), .din(SPI_SCK),
      .dout(sck_lvl), .rise(sck_rise), .fall(sck_fall)
   );

   spislave_sync #(.RESET_VAL(1'b0)) u_sync_ssel (
      .clk(clk), .reset(reset), .din(SPI_SSEL),
      .dout(ssel_lvl), .rise(ssel_rise), .fall(ssel_fall)
   );

   spislave_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .din(SPI_MOSI),
      .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
   );

   assign unused_sig = ^{sck_lvl, ssel_lvl, mosi_rise, mosi_fall};

   // Map SPI mode onto sample/shift strobes.
   always_comb begin
      lead_edge   = CPOL ? sck_fall : sck_rise;
      trail_edge  = CPOL ? sck_rise : sck_fall;
      sample_edge = CPHA ? trail_edge : lead_edge;
      shift_edge  = CPHA ? lead_edge  : trail_edge;
   end

   // Frame acceptance: exact length and matching on-wire header.
   always_comb begin
      frame_ok = (bit_cnt == CNT_FULL) &&
                 (rx_sreg[BUFFER_SIZE-1 -: HDR_WIDTH] == HDR_EXP);
      reload   = (state == ST_CHECK) && frame_ok;
   end

   // Frame FSM, shift registers, bit counter and error counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         rx_sreg   <= '0;
         tx_sreg   <= '0;
         miso_q    <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         err_count <= '0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               miso_q <= 1'b0;
               if (ssel_fall) begin
                  state   <= ST_ACTIVE;
                  bit_cnt <= '0;
                  rx_sreg <= '0;
                  if (CPHA) begin
                     tx_sreg <= tx_data;
                  end else begin
                     miso_q  <= tx_data[BUFFER_SIZE-1];
                     tx_sreg <= {tx_data[BUFFER_SIZE-2:0], 1'b0};
                  end
               end
            end
            ST_ACTIVE: begin
               if (sample_edge) begin
                  if (bit_cnt < CNT_FULL) begin
                     rx_sreg <= {rx_sreg[BUFFER_SIZE-2:0], mosi_s};
                  end
                  if (bit_cnt != CNT_SAT) begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
               // In CPHA=0 the MSB is already out, so a shift edge before the first sample is ignored.
               if (shift_edge && (CPHA || (bit_cnt != '0))) begin
                  miso_q  <= tx_sreg[BUFFER_SIZE-1];
                  tx_sreg <= {tx_sreg[BUFFER_SIZE-2:0], 1'b0};
               end
               if (ssel_rise) begin
                  state  <= ST_CHECK;
                  miso_q <= 1'b0;
               end
            end
            ST_CHECK: begin
               state <= ST_IDLE;
               if (frame_ok) begin
                  rx_data  <= rx_sreg;
                  rx_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign SPI_MISO = miso_q;

   // Timeout down-counter; a reload takes priority over expiry.
   always_comb begin
      tmo_next = tmo_cnt;
      if (reload) begin
         tmo_next = TIMEOUT;
      end else if (tmo_cnt != 32'd0) begin
         tmo_next = tmo_cnt - 32'd1;
      end
   end

   // Timeout register and its registered zero flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt     <= 32'd0;
         pkg_timeout <= 1'b1;
      end else begin
         tmo_cnt     <= tmo_next;
         pkg_timeout <= (tmo_next == 32'd0);
      end
   end

endmodule

// File: tb/tb_interface_spislave_ext.sv
// Bench for interface_spislave_ext: four instances (SPI modes 0..3) driven by a
// bit-banged host model; frame results are checked through a scoreboard queue.
module tb_interface_spislave_ext;

   localparam int BS = 96;
   localparam int H  = 4;   // half SCK period in clk cycles (clk = 8x SCK)

   logic clk = 1'b0;
   logic reset;
   logic sck [4];
   logic ssel [4];
   logic mosi [4];
   logic miso [4];
   logic rxv [4];
   logic ferr [4];
   logic tmo [4];
   logic [BS-1:0] rxd [4];
   logic [7:0] errc [4];
   logic [BS-1:0] tx_data;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int rxv_cyc [4];

   typedef struct {
      int            id;
      bit            valid;
      logic [BS-1:0] data;
      logic [7:0]    errc;
   } exp_t;

   exp_t          sb[$];
   logic [BS-1:0] exp_rx [4];
   logic [7:0]    exp_err [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      interface_spislave_ext #(
         .BUFFER_SIZE(BS),
         .MSGID(32'h74697277),
         .CPOL(g >= 2),
         .CPHA(g % 2 == 1),
         .TIMEOUT((g == 3) ? 32'd1000 : 32'd100)
      ) u_dut (
         .clk(clk),
         .reset(reset),
         .SPI_SCK(sck[g]),
         .SPI_SSEL(ssel[g]),
         .SPI_MOSI(mosi[g]),
         .SPI_MISO(miso[g]),
         .tx_data(tx_data),
         .rx_data(rxd[g]),
         .rx_valid(rxv[g]),
         .frame_err(ferr[g]),
         .err_count(errc[g]),
         .pkg_timeout(tmo[g])
      );
   end

   task automatic chk(input string tag, input logic [BS-1:0] obs, input logic [BS-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_exp(input int id, input bit valid, input logic [BS-1:0] fr);
      exp_t e;
      e.id    = id;
      e.valid = valid;
      if (valid) exp_rx[id] = fr;
      else if (exp_err[id] != 8'hFF) exp_err[id] = exp_err[id] + 8'd1;
      e.data = exp_rx[id];
      e.errc = exp_err[id];
      sb.push_back(e);
   endtask

   task automatic frame_start(input int id);
      ssel[id] = 1'b0;
      tick(8);
   endtask

   task automatic frame_bits(input int id, input logic [127:0] fb, input int n,
                             output logic [127:0] cap);
      bit cpol, cpha;
      cpol = (id >= 2);
      cpha = (id % 2 == 1);
      cap  = '0;
      for (int k = n - 1; k >= 0; k--) begin
         if (!cpha) begin
            mosi[id] = fb[k];
            tick(H);
            sck[id] = ~cpol;
            cap = {cap[126:0], miso[id]};
            tick(H);
            sck[id] = cpol;
         end else begin
            sck[id]  = ~cpol;
            mosi[id] = fb[k];
            tick(H);
            sck[id] = cpol;
            cap = {cap[126:0], miso[id]};
            tick(H);
         end
      end
      tick(H);
      mosi[id] = 1'b0;
   endtask

   task automatic frame_end(input int id, input logic [127:0] fb, input int n);
      logic [BS-1:0] fr;
      fr = fb[BS-1:0];
      push_exp(id, (n == BS) && (fr[BS-1 -: 32] == 32'h77726974), fr);
      ssel[id] = 1'b1;
      tick(8);
   endtask

   task automatic glitch(input int id);
      push_exp(id, 1'b0, '0);
      ssel[id] = 1'b0;
      tick(2);
      ssel[id] = 1'b1;
      tick(8);
   endtask

   // Scoreboard: every rx_valid/frame_err pulse must match the next expected entry.
   always @(negedge clk) begin : mon
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         if (rxv[i] === 1'b1 || ferr[i] === 1'b1) begin
            if (sb.size() == 0) begin
               chk($sformatf("unexpected_pulse_dut%0d", i), BS'({rxv[i], ferr[i]}), '0);
            end else begin
               e = sb.pop_front();
               chk("pulse_dut", BS'(i), BS'(e.id));
               chk($sformatf("pulse_kind_dut%0d", i), BS'({rxv[i], ferr[i]}),
                   BS'({e.valid, ~e.valid}));
               chk($sformatf("rx_data_dut%0d", i), rxd[i], e.data);
               chk($sformatf("err_count_dut%0d", i), BS'(errc[i]), BS'(e.errc));
               if (e.valid) begin
                  chk($sformatf("tmo_at_valid_dut%0d", i), BS'(tmo[i]), '0);
                  rxv_cyc[i] = cyc;
               end
            end
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] good, bad_hdr, f95, f97, cap;
      logic [BS-1:0] tx_a;
      int e0;

      good    = {32'h0, 32'h77726974, 64'h1717171717171717};
      bad_hdr = {32'h0, 32'h00000000, 64'h1717171717171717};
      f95     = good >> 1;
      f97     = {good[126:0], 1'b1};
      tx_a    = 96'hA5C3_0F1E_2D3C_4B5A_6978_8796;

      reset   = 1'b1;
      tx_data = '0;
      for (int i = 0; i < 4; i++) begin
         sck[i]     = (i >= 2);
         ssel[i]    = 1'b1;
         mosi[i]    = 1'b0;
         exp_rx[i]  = '0;
         exp_err[i] = '0;
         rxv_cyc[i] = 0;
      end
      tick(3);
      reset = 1'b0;
      tick(2);

      // Reset values on every instance
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_rx_data%0d", i), rxd[i], '0);
         chk($sformatf("rst_rx_valid%0d", i), BS'(rxv[i]), '0);
         chk($sformatf("rst_frame_err%0d", i), BS'(ferr[i]), '0);
         chk($sformatf("rst_err_count%0d", i), BS'(errc[i]), '0);
         chk($sformatf("rst_miso%0d", i), BS'(miso[i]), '0);
         chk($sformatf("rst_timeout%0d", i), BS'(tmo[i]), BS'(1));
      end

      // Mode 0 valid frame; tx_data changes after frame start and must be ignored
      tx_data = tx_a;
      frame_start(0);
      tx_data = ~tx_a;
      frame_bits(0, good, 96, cap);
      chk("miso_mode0", cap[BS-1:0], tx_a);
      frame_end(0, good, 96);
      chk("miso_idle0", BS'(miso[0]), '0);

      // Timeout expiry 100 cycles after the rx_valid cycle
      e0 = rxv_cyc[0];
      while (cyc < e0 + 99) tick(1);
      chk("tmo_before_expiry", BS'(tmo[0]), '0);
      tick(1);
      chk("tmo_expired", BS'(tmo[0]), BS'(1));

      // Modes 1..3 with the same frame
      for (int id = 1; id < 4; id++) begin
         tx_data = tx_a;
         frame_start(id);
         tx_data = ~tx_a;
         frame_bits(id, good, 96, cap);
         chk($sformatf("miso_mode%0d", id), cap[BS-1:0], tx_a);
         frame_end(id, good, 96);
      end

      // Second valid frame on mode 3 whose reload lands exactly on expiry (TIMEOUT=1000)
      e0 = rxv_cyc[3];
      frame_start(3);
      frame_bits(3, good, 96, cap);
      while (cyc < e0 + 996) tick(1);
      chk("tmo_near_expiry", BS'(tmo[3]), '0);
      frame_end(3, good, 96);
      chk("reload_cycle", BS'(rxv_cyc[3]), BS'(e0 + 1000));
      chk("tmo_after_reload", BS'(tmo[3]), '0);

      // Rejected frames on mode 0: bad header, 95 bits, 97 bits
      frame_start(0);
      frame_bits(0, bad_hdr, 96, cap);
      frame_end(0, bad_hdr, 96);
      frame_start(0);
      frame_bits(0, f95, 95, cap);
      frame_end(0, f95, 95);
      frame_start(0);
      frame_bits(0, f97, 97, cap);
      frame_end(0, f97, 97);
      chk("err_count_3", BS'(errc[0]), BS'(3));

      // SSEL glitches (0-bit frames) saturate the error counter
      for (int k = 0; k < 300; k++) glitch(0);
      chk("err_count_sat", BS'(errc[0]), BS'(255));
      chk("rx_data_kept", rxd[0], good[BS-1:0]);

      // Reset in the middle of a frame
      tx_data = tx_a;
      frame_start(0);
      frame_bits(0, good >> 56, 40, cap);
      reset = 1'b1;
      tick(2);
      for (int i = 0; i < 4; i++) begin
         exp_rx[i]  = '0;
         exp_err[i] = '0;
      end
      chk("midrst_rx_data", rxd[0], '0);
      chk("midrst_rx_valid", BS'(rxv[0]), '0);
      chk("midrst_frame_err", BS'(ferr[0]), '0);
      chk("midrst_err_count", BS'(errc[0]), '0);
      chk("midrst_miso", BS'(miso[0]), '0);
      chk("midrst_timeout", BS'(tmo[0]), BS'(1));
      reset = 1'b0;
      tick(2);
      frame_bits(0, good, 56, cap);
      ssel[0] = 1'b1;
      tick(12);
      chk("midrst_no_pulse_err", BS'(errc[0]), '0);

      // Fresh valid frame after the aborted one
      frame_start(0);
      frame_bits(0, good, 96, cap);
      chk("miso_after_reset", cap[BS-1:0], tx_a);
      frame_end(0, good, 96);

      tick(10);
      chk("scoreboard_drained", BS'(sb.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
